// File: rtl/bus_to_bb_addr_pkg.sv
// ---------------------------------------------------------------------------
// bus_to_bb_addr_pkg
// Shared definitions for the serial-bus-address to bridge-address
// deserialiser: FSM state encoding and default width constants.
// Optional feature macro used by this block: ADDR_RANGE_CHECK_EN.
// ---------------------------------------------------------------------------
package bus_to_bb_addr_pkg;

    localparam int DEF_BB_ADDR_WIDTH      = 12;
    localparam int DEF_BUS_ADDR_WIDTH     = 16;
    localparam int DEF_BUS_MEM_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage : bus_to_bb_addr_pkg

// File: rtl/bus_to_bb_addr_if.sv
// ---------------------------------------------------------------------------
// bus_to_bb_addr_if
// Groups the serial address input channel and the bridge-side output slice.
//   addr_in / addr_in_valid / addr_in_ready : serial address bits, LSB first
//   bb_addr / bb_valid / bb_ready / addr_err : reconstructed bridge address
// Modports:
//   slave  : the deserialiser (consumes serial bits, produces bb_*)
//   master : the environment (drives serial bits and bb_ready)
// ---------------------------------------------------------------------------
interface bus_to_bb_addr_if #(
    parameter int BB_ADDR_WIDTH = bus_to_bb_addr_pkg::DEF_BB_ADDR_WIDTH
);

    logic                     addr_in;
    logic                     addr_in_valid;
    logic                     addr_in_ready;
    logic [BB_ADDR_WIDTH-1:0] bb_addr;
    logic                     bb_valid;
    logic                     bb_ready;
    logic                     addr_err;

    modport slave (
        input  addr_in,
        input  addr_in_valid,
        input  bb_ready,
        output addr_in_ready,
        output bb_addr,
        output bb_valid,
        output addr_err
    );

    modport master (
        output addr_in,
        output addr_in_valid,
        output bb_ready,
        input  addr_in_ready,
        input  bb_addr,
        input  bb_valid,
        input  addr_err
    );

endinterface : bus_to_bb_addr_if

// File: rtl/bus_addr_shift_rx.sv
// ---------------------------------------------------------------------------
// bus_addr_shift_rx
// LSB-first shift register plus bit counter for one serial address frame.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   bit_i      : serial bit presented this cycle
//   beat_i     : bit_i is accepted on this edge
//   word_o     : the frame word as it will be after this cycle's shift
//   done_o     : this beat carries the final bit of the frame
// Only BUS_ADDR_WIDTH-1 bits are stored: the final bit never needs a flop
// because the consumer loads word_o on the same edge that accepts it.
// ---------------------------------------------------------------------------
module bus_addr_shift_rx
    import bus_to_bb_addr_pkg::*;
#(
    parameter  int BUS_ADDR_WIDTH = DEF_BUS_ADDR_WIDTH,
    localparam int CNT_W          = $clog2(BUS_ADDR_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      bit_i,
    input  logic                      beat_i,
    output logic [BUS_ADDR_WIDTH-1:0] word_o,
    output logic                      done_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUS_ADDR_WIDTH - 1);

    logic [BUS_ADDR_WIDTH-2:0] sr_q;
    logic [BUS_ADDR_WIDTH-2:0] sr_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;

    assign word_o = {bit_i, sr_q};
    assign done_o = beat_i & (cnt_q == LAST_CNT);

    // Next shift-register and bit-count values for an accepted beat.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (beat_i) begin
            sr_d = word_o[BUS_ADDR_WIDTH-1:1];
            if (done_o) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
    end

    // Shift-register and counter flops; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sr_q  <= {(BUS_ADDR_WIDTH-1){1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule : bus_addr_shift_rx

// File: rtl/bus_to_bb_addr.sv
// ---------------------------------------------------------------------------
// bus_to_bb_addr
// Deserialises an LSB-first bus address frame and rebuilds the bridge
// address, presenting it on a valid/ready register slice.
// Ports:
//   clk   : clock, rising edge
//   rstn  : synchronous active-low reset
//   bus   : bus_to_bb_addr_if.slave (addr_in/valid/ready in, bb_* out)
// Mapping of final word w:
//   bb_addr[BB-2:0] = w[BB-2:0], bb_addr[BB-1] = w[BUS_MEM_ADDR_WIDTH]
// Optional feature macro: ADDR_RANGE_CHECK_EN -- when defined, addr_err flags
// frames with any set bit outside the mapped fields; otherwise addr_err is 0.
// ---------------------------------------------------------------------------
module bus_to_bb_addr
    import bus_to_bb_addr_pkg::*;
#(
    parameter int BB_ADDR_WIDTH      = DEF_BB_ADDR_WIDTH,
    parameter int BUS_ADDR_WIDTH     = DEF_BUS_ADDR_WIDTH,
    parameter int BUS_MEM_ADDR_WIDTH = DEF_BUS_MEM_ADDR_WIDTH
) (
    input logic             clk,
    input logic             rstn,
    bus_to_bb_addr_if.slave bus
);

    state_e                    state_q;
    state_e                    state_d;
    logic [BB_ADDR_WIDTH-1:0]  bb_addr_q;
    logic [BB_ADDR_WIDTH-1:0]  bb_addr_d;
    logic                      bb_valid_q;
    logic                      bb_valid_d;
    logic                      addr_err_q;
    logic                      addr_err_d;

    logic                      ready_s;
    logic                      beat_s;
    logic                      done_s;
    logic                      range_err_s;
    logic [BUS_ADDR_WIDTH-1:0] word_s;

    // Keep the low bridge bits and move the slave-select bit to the bridge MSB.
    function automatic logic [BB_ADDR_WIDTH-1:0] map_addr(input logic [BUS_ADDR_WIDTH-1:0] w);
        logic [BB_ADDR_WIDTH-1:0] a;
        a                  = {BB_ADDR_WIDTH{1'b0}};
        a[BB_ADDR_WIDTH-2:0] = w[BB_ADDR_WIDTH-2:0];
        a[BB_ADDR_WIDTH-1]   = w[BUS_MEM_ADDR_WIDTH];
        return a;
    endfunction

    // Any set bit at or above BB_ADDR_WIDTH-1, other than the select bit, is lost.
    function automatic logic out_of_range(input logic [BUS_ADDR_WIDTH-1:0] w);
        logic e;
        e = 1'b0;
        for (int i = BB_ADDR_WIDTH - 1; i < BUS_ADDR_WIDTH; i++) begin
            if (i != BUS_MEM_ADDR_WIDTH) begin
                e = e | w[i];
            end else begin
                e = e;
            end
        end
        return e;
    endfunction

    // Backpressure while a result is held; nothing is accepted during reset.
    assign ready_s = rstn & (state_q != ST_HOLD);
    assign beat_s  = bus.addr_in_valid & ready_s;

    bus_addr_shift_rx #(
        .BUS_ADDR_WIDTH (BUS_ADDR_WIDTH)
    ) u_shift_rx (
        .clk    (clk),
        .rstn   (rstn),
        .bit_i  (bus.addr_in),
        .beat_i (beat_s),
        .word_o (word_s),
        .done_o (done_s)
    );

`ifdef ADDR_RANGE_CHECK_EN
    assign range_err_s = out_of_range(word_s);
`else
    // Range bits are evaluated but intentionally dropped: truncation is silent.
    logic unused_range_s;
    assign unused_range_s = out_of_range(word_s);
    assign range_err_s    = 1'b0;
`endif

    // FSM next state and output-slice loads.
    always_comb begin
        state_d    = state_q;
        bb_addr_d  = bb_addr_q;
        bb_valid_d = bb_valid_q;
        addr_err_d = addr_err_q;
        case (state_q)
            ST_IDLE, ST_RECV: begin
                if (done_s) begin
                    state_d    = ST_HOLD;
                    bb_addr_d  = map_addr(word_s);
                    addr_err_d = range_err_s;
                    bb_valid_d = 1'b1;
                end else if (beat_s) begin
                    state_d = ST_RECV;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (bus.bb_ready) begin
                    state_d    = ST_IDLE;
                    bb_valid_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                bb_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            bb_addr_q  <= {BB_ADDR_WIDTH{1'b0}};
            bb_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bb_addr_q  <= bb_addr_d;
            bb_valid_q <= bb_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.addr_in_ready = ready_s;
    assign bus.bb_addr       = bb_addr_q;
    assign bus.bb_valid      = bb_valid_q;
    assign bus.addr_err      = addr_err_q;

endmodule : bus_to_bb_addr

// File: tb/tb_bus_to_bb_addr.sv
// ---------------------------------------------------------------------------
// tb_bus_to_bb_addr
// Self-checking bench for bus_to_bb_addr with the default 12/16/12 widths.
// Expected addresses/errors come from an arithmetic model of the mapping.
// ---------------------------------------------------------------------------
module tb_bus_to_bb_addr;

    localparam int BB  = 12;
    localparam int BUS = 16;
    localparam int MEM = 12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_to_bb_addr_if #(.BB_ADDR_WIDTH(BB)) bus_if ();

    bus_to_bb_addr #(
        .BB_ADDR_WIDTH      (BB),
        .BUS_ADDR_WIDTH     (BUS),
        .BUS_MEM_ADDR_WIDTH (MEM)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if.slave)
    );

    // Reference: low BB-1 bits kept, bit MEM becomes the bridge MSB.
    function automatic logic [BB-1:0] model_addr(input logic [BUS-1:0] w);
        int v;
        int r;
        v = int'(w);
        r = (v % (1 << (BB - 1))) + (((v >> MEM) % 2) << (BB - 1));
        return BB'(r);
    endfunction

    // Reference: anything above the kept field other than the select bit is an error.
    function automatic logic model_err(input logic [BUS-1:0] w);
`ifdef ADDR_RANGE_CHECK_EN
        int hi;
        hi = int'(w) >> (BB - 1);
        hi = hi & ~(1 << (MEM - (BB - 1)));
        return (hi != 0);
`else
        return (w != w);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame LSB-first with optional random gaps; ends #1 after the last-bit edge.
    task automatic send_frame(input logic [BUS-1:0] w, input int max_gap);
        for (int i = 0; i < BUS; i++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 0);
                bus_if.addr_in_valid = 1'b0;
                bus_if.addr_in       = 1'($urandom);
                repeat (g) tick();
            end
            bus_if.addr_in       = w[i];
            bus_if.addr_in_valid = 1'b1;
            if (i == BUS - 1) begin
                vectors++;
                if (bus_if.bb_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL early_valid: bb_valid=%b before last bit, required 0", bus_if.bb_valid);
                end
            end
            tick();
        end
        bus_if.addr_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus_if.addr_in_valid = 1'b1;
        bus_if.addr_in       = 1'b1;
        repeat (3) tick();
        vectors++;
        if (bus_if.addr_in_ready !== 1'b0 || bus_if.bb_valid !== 1'b0 ||
            bus_if.bb_addr !== 12'h000 || bus_if.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b valid=%b addr=%h err=%b, required 0/0/000/0",
                     bus_if.addr_in_ready, bus_if.bb_valid, bus_if.bb_addr, bus_if.addr_err);
        end
        bus_if.addr_in_valid = 1'b0;
        rstn = 1'b1;
        #1;
        vectors++;
        if (bus_if.addr_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready: ready=%b, required 1", bus_if.addr_in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [BUS-1:0] w;
        w = 16'h1123;
        bus_if.bb_ready = 1'b1;
        send_frame(w, 0);
        vectors++;
        if (bus_if.bb_valid !== 1'b1 || bus_if.bb_addr !== 12'h923 || bus_if.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: valid=%b addr=%h err=%b, required 1/923/0",
                     bus_if.bb_valid, bus_if.bb_addr, bus_if.addr_err);
        end
        tick();
        vectors++;
        if (bus_if.bb_valid !== 1'b0 || bus_if.addr_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_one_cycle: valid=%b ready=%b, required 0/1",
                     bus_if.bb_valid, bus_if.addr_in_ready);
        end
        bus_if.bb_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus_if.bb_ready = 1'b0;
        send_frame(16'h07FF, 0);
        // Bits offered during the hold must be ignored.
        for (int c = 0; c < 5; c++) begin
            bus_if.addr_in_valid = 1'b1;
            bus_if.addr_in       = 1'b1;
            vectors++;
            if (bus_if.bb_valid !== 1'b1 || bus_if.bb_addr !== 12'h7FF || bus_if.addr_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: valid=%b addr=%h ready=%b, required 1/7ff/0",
                         c, bus_if.bb_valid, bus_if.bb_addr, bus_if.addr_in_ready);
            end
            tick();
        end
        bus_if.addr_in_valid = 1'b0;
        bus_if.bb_ready      = 1'b1;
        tick();
        bus_if.bb_ready = 1'b0;
        vectors++;
        if (bus_if.bb_valid !== 1'b0 || bus_if.addr_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: valid=%b ready=%b, required 0/1",
                     bus_if.bb_valid, bus_if.addr_in_ready);
        end
        send_frame(16'h0123, 0);
        vectors++;
        if (bus_if.bb_valid !== 1'b1 || bus_if.bb_addr !== 12'h123) begin
            miscompares++;
            $display("FAIL after_hold_frame: valid=%b addr=%h, required 1/123",
                     bus_if.bb_valid, bus_if.bb_addr);
        end
        bus_if.bb_ready = 1'b1;
        tick();
        bus_if.bb_ready = 1'b0;
    endtask

    task automatic test_range();
        logic [BUS-1:0] words [2];
        logic [BB-1:0]  addrs [2];
        words[0] = 16'h0ABC; addrs[0] = 12'h2BC;
        words[1] = 16'h2001; addrs[1] = 12'h001;
        for (int k = 0; k < 2; k++) begin
            send_frame(words[k], 0);
            vectors++;
            if (bus_if.bb_valid !== 1'b1 || bus_if.bb_addr !== addrs[k] ||
                bus_if.addr_err !== model_err(words[k])) begin
                miscompares++;
                $display("FAIL range_%h: valid=%b addr=%h err=%b, required 1/%h/%b", words[k],
                         bus_if.bb_valid, bus_if.bb_addr, bus_if.addr_err, addrs[k], model_err(words[k]));
            end
            bus_if.bb_ready = 1'b1;
            tick();
            bus_if.bb_ready = 1'b0;
        end
    endtask

    task automatic test_gaps();
        send_frame(16'h1000, 3);
        vectors++;
        if (bus_if.bb_valid !== 1'b1 || bus_if.bb_addr !== 12'h800 || bus_if.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_result: valid=%b addr=%h err=%b, required 1/800/0",
                     bus_if.bb_valid, bus_if.bb_addr, bus_if.addr_err);
        end
        bus_if.bb_ready = 1'b1;
        tick();
        bus_if.bb_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 7; i++) begin
            bus_if.addr_in       = 1'b1;
            bus_if.addr_in_valid = 1'b1;
            tick();
        end
        rstn = 1'b0;
        repeat (2) tick();
        vectors++;
        if (bus_if.addr_in_ready !== 1'b0 || bus_if.bb_valid !== 1'b0 || bus_if.bb_addr !== 12'h000) begin
            miscompares++;
            $display("FAIL midframe_reset: ready=%b valid=%b addr=%h, required 0/0/000",
                     bus_if.addr_in_ready, bus_if.bb_valid, bus_if.bb_addr);
        end
        bus_if.addr_in_valid = 1'b0;
        rstn = 1'b1;
        tick();
        send_frame(16'h0005, 0);
        vectors++;
        if (bus_if.bb_valid !== 1'b1 || bus_if.bb_addr !== 12'h005 || bus_if.addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_frame: valid=%b addr=%h err=%b, required 1/005/0",
                     bus_if.bb_valid, bus_if.bb_addr, bus_if.addr_err);
        end
        bus_if.bb_ready = 1'b1;
        tick();
        bus_if.bb_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [BUS-1:0] w;
            int             hold;
            w    = BUS'($urandom);
            hold = $urandom_range(3, 0);
            send_frame(w, 2);
            for (int c = 0; c <= hold; c++) begin
                vectors++;
                if (bus_if.bb_valid !== 1'b1 || bus_if.bb_addr !== model_addr(w) ||
                    bus_if.addr_err !== model_err(w) || bus_if.addr_in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL random_%0d word %h: valid=%b addr=%h err=%b ready=%b, required 1/%h/%b/0",
                             n, w, bus_if.bb_valid, bus_if.bb_addr, bus_if.addr_err,
                             bus_if.addr_in_ready, model_addr(w), model_err(w));
                end
                if (c == hold) begin
                    bus_if.bb_ready = 1'b1;
                end
                tick();
            end
            bus_if.bb_ready = 1'b0;
            vectors++;
            if (bus_if.bb_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL random_%0d release: valid=%b, required 0", n, bus_if.bb_valid);
            end
        end
    endtask

    initial begin
        bus_if.addr_in       = 1'b0;
        bus_if.addr_in_valid = 1'b0;
        bus_if.bb_ready      = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_range();
        test_gaps();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bus_to_bb_addr
